// File: rtl/vtg_pkg.sv
// vtg_pkg: timing-set type, 640x480@60 defaults, TMDS control symbols and generator states.
package vtg_pkg;
  typedef struct packed {
    int h_active, h_fp, h_sync, h_bp;
    int v_active, v_fp, v_sync, v_bp;
  } timing_t;
  localparam timing_t VGA_640X480 = '{h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
                                      v_active: 480, v_fp: 10, v_sync: 2, v_bp: 33};
  // Control-period symbols indexed by {vsync, hsync} for the downstream TMDS mux.
  localparam logic [9:0] TMDS_CTRL_00 = 10'b1101010100;
  localparam logic [9:0] TMDS_CTRL_01 = 10'b0010101011;
  localparam logic [9:0] TMDS_CTRL_10 = 10'b0101010100;
  localparam logic [9:0] TMDS_CTRL_11 = 10'b1010101011;
  typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/vtg_if.sv
// vtg_if: run control, request stream and display stream of the timing generator.
// VTG_PATTERN_EN adds the colour-bar outputs.
interface vtg_if #(parameter int CW = 12);
  logic en, req, de, hsync, vsync, sof, sol, running;
  logic [CW-1:0] req_x, req_y, x, y;
`ifdef VTG_PATTERN_EN
  logic [7:0] pat_r, pat_g, pat_b;
`endif
  modport master (input en, output req, req_x, req_y, de, hsync, vsync, x, y, sof, sol, running
`ifdef VTG_PATTERN_EN
    , output pat_r, pat_g, pat_b
`endif
  );
  modport slave (output en, input req, req_x, req_y, de, hsync, vsync, x, y, sof, sol, running
`ifdef VTG_PATTERN_EN
    , input pat_r, pat_g, pat_b
`endif
  );
endinterface

// File: rtl/vtg_delay.sv
// vtg_delay: W-bit, D-deep shift register with async reset value RV; D=0 is a plain wire.
module vtg_delay #(
  parameter int W = 1,
  parameter int D = 1,
  parameter logic [W-1:0] RV = '0
)(
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  if (D == 0) begin : g_wire
    assign q = d;
  end else begin : g_pipe
    logic [W-1:0] sr [D];
    always_ff @(posedge clk or posedge rst)
      if (rst) for (int i = 0; i < D; i++) sr[i] <= RV;
      else begin
        sr[0] <= d;
        for (int i = 1; i < D; i++) sr[i] <= sr[i-1];
      end
    assign q = sr[D-1];
  end
endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing with a request stream and a LEAD-delayed display stream.
// VTG_PATTERN_EN adds 8 vertical colour bars aligned with de.
module video_timing_gen import vtg_pkg::*; #(
  parameter int H_ACTIVE = VGA_640X480.h_active,
  parameter int H_FP     = VGA_640X480.h_fp,
  parameter int H_SYNC   = VGA_640X480.h_sync,
  parameter int H_BP     = VGA_640X480.h_bp,
  parameter int V_ACTIVE = VGA_640X480.v_active,
  parameter int V_FP     = VGA_640X480.v_fp,
  parameter int V_SYNC   = VGA_640X480.v_sync,
  parameter int V_BP     = VGA_640X480.v_bp,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 12,
  parameter int LEAD     = 2
)(
  input  logic clk,
  input  logic rst,
  vtg_if.master v
);
  localparam logic [CW-1:0] HA  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] HS0 = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS1 = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] HT1 = CW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CW-1:0] VA  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] VS0 = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS1 = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] VT1 = CW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
`ifdef VTG_PATTERN_EN
  localparam int PW = 24;
`else
  localparam int PW = 0;
`endif
  localparam int SW = 5 + 2*CW + PW;
  state_t state, state_n;
  logic [CW-1:0] hc, vc, hc_n, vc_n;
  logic h_end, f_end, run, act, hs_a, vs_a, d_hs, d_vs;
  logic [SW-PW-1:0] flags;
  logic [SW-1:0] rq_n, rq, dq;
  always_comb begin
    h_end   = hc == HT1;
    f_end   = h_end && vc == VT1;
    run     = state == RUN;
    state_n = run ? ((f_end && !v.en) ? IDLE : RUN) : (v.en ? RUN : IDLE);
    hc_n    = (!run || h_end) ? '0 : hc + 1'b1;
    vc_n    = (!run || f_end) ? '0 : (h_end ? vc + 1'b1 : vc);
    act     = run && hc < HA && vc < VA;
    hs_a    = run && hc >= HS0 && hc < HS1;
    // vsync edges line up with the hsync leading edge, not with hc=0.
    vs_a    = run && ((vc == VS0 && hc >= HS0) || (vc > VS0 && vc < VS1) || (vc == VS1 && hc < HS0));
    flags   = {act, hs_a, vs_a, act && hc == '0 && vc == '0, act && hc == '0,
               act ? vc : '0, act ? hc : '0};
  end
`ifdef VTG_PATTERN_EN
  localparam logic [CW-1:0] BW = CW'(H_ACTIVE / 8);
  logic [CW-1:0] bar;
  logic [2:0] b;
  always_comb begin
    bar  = hc / BW;
    b    = (bar > CW'(7)) ? 3'd7 : bar[2:0];
    rq_n = {flags, act ? {{8{!b[1]}}, {8{!b[2]}}, {8{!b[0]}}} : 24'h0};
  end
  assign {v.pat_r, v.pat_g, v.pat_b} = dq[PW-1:0];
`else
  assign rq_n = flags;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      hc    <= '0;
      vc    <= '0;
      rq    <= '0;
    end else begin
      state <= state_n;
      hc    <= hc_n;
      vc    <= vc_n;
      rq    <= rq_n;
    end
  vtg_delay #(.W(SW), .D(LEAD)) u_dly (.clk(clk), .rst(rst), .d(rq), .q(dq));
  assign v.running = state == RUN;
  assign v.req     = rq[SW-1];
  assign v.req_y   = rq[PW+CW +: CW];
  assign v.req_x   = rq[PW +: CW];
  assign {v.de, d_hs, d_vs, v.sof, v.sol, v.y, v.x} = dq[SW-1:PW];
  assign v.hsync   = d_hs ? HS_POL : !HS_POL;
  assign v.vsync   = d_vs ? VS_POL : !VS_POL;
endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Parametrised raster timing generator for the HDMI/DVI transmit path, running in the pixel clock domain. It produces the pixel-fetch request stream (position plus valid) and a display-aligned stream: data enable, hsync, vsync, x/y, and start-of-frame/line strobes. The display stream is delayed by a configurable lead so a fixed-latency pixel source lines up with the TMDS encoders. All timings and sync polarities are parameters; start/stop is gated to frame boundaries.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch, sync width, back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical front porch, sync width, back porch (lines)
- HS_POL / VS_POL, 0 / 0, asserted level of hsync / vsync (0 = active-low)
- CW, 12, counter and coordinate width; must satisfy 2^CW > max(H_TOTAL, V_TOTAL)
- LEAD, 2, cycles between request stream and display stream (0 allowed)

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  run request; sampled only at frame boundary
- req  out  1  pixel fetch request (active region, request stream)
- req_x, req_y  out  CW  coordinate being requested
- de  out  1  data enable, display stream
- hsync, vsync  out  1  syncs at configured polarity, display stream
- x, y  out  CW  coordinate of current displayed pixel
- sof  out  1  one-cycle pulse with pixel (0,0) on display stream
- sol  out  1  one-cycle pulse with pixel (0,y) for every active line
- running  out  1  generator is producing frames

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Internal counters hc in 0..H_TOTAL-1, vc in 0..V_TOTAL-1; hc wraps to 0 and vc increments at hc==H_TOTAL-1; vc wraps at V_TOTAL-1.
- States: IDLE, RUN. IDLE: hc=vc=0 held, running=0. IDLE->RUN when en=1 (counters start next cycle at 0,0). RUN->IDLE only at frame wrap (hc==H_TOTAL-1, vc==V_TOTAL-1) with en=0; mid-frame en deassertion completes the frame.
- Active region: hc<H_ACTIVE and vc<V_ACTIVE.
- hsync asserted for H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC.
- vsync edges coincide with hsync leading edge: asserted from (vc=V_ACTIVE+V_FP, hc=H_ACTIVE+H_FP) up to (vc=V_ACTIVE+V_FP+V_SYNC, hc=H_ACTIVE+H_FP), exclusive.
- Request stream: req, req_x, req_y registered from counters; req_x/req_y = hc/vc when req=1, else 0.
- Display stream: de, hsync, vsync, x, y, sof, sol are request-stream values (raw positional flags) delayed LEAD cycles; x/y zero when de=0.
- In IDLE all strobes 0, syncs at inactive level, so sink sees continuous control period.

## Timing
- Reset values: req=de=sof=sol=running=0; all coordinates 0; hsync=!HS_POL, vsync=!VS_POL; delay line flushed to the same idle values.
- req latency: 1 cycle from counter state. Display latency: 1+LEAD cycles.
- running rises the cycle after en is sampled in IDLE; first req the following cycle (with hc=0).
- Reset mid-frame: immediate return to IDLE, delay line cleared; no partial strobes emitted after rst.
- en toggled within a frame: no effect until frame wrap.

## Configuration
- VTG_PATTERN_EN defined: adds outputs pat_r, pat_g, pat_b (8 bits each), 8 vertical colour bars of width H_ACTIVE/8 (white, yellow, cyan, green, magenta, red, blue, black), registered and aligned with de; zero when de=0.
- Not defined: ports and logic absent; behaviour otherwise identical.

## Structure
- Package vtg_pkg: timing-set typedef (struct of the eight H/V fields), default 640x480@60 constants, TMDS control-symbol constants for the downstream mux, state enum.
- Sub-module vtg_delay: parametrised width/depth shift register with async-reset value, used for the LEAD alignment (depth 0 = wire).

## Test plan
- Defaults, en=1 from reset -> first req 2 cycles after en, de first high LEAD=2 cycles after req; 640 de cycles per line, 480 active lines, 800x525 cycles per frame.
- hsync check -> low for exactly 96 cycles starting 16 cycles after last de of a line; vsync low spans 2x800 cycles starting at hsync falling edge of line 490.
- HS_POL=1, VS_POL=1, LEAD=0 -> syncs active-high; de/x/y equal req/req_x/req_y same cycle.
- en dropped at line 100 -> frame completes to (799,524), running falls, no further req; en reasserted -> restart at (0,0).
- rst pulse at line 300 -> all outputs to reset values asynchronously; sof absent until a new frame starts.
- VTG_PATTERN_EN, defaults -> x=0 yields FF/FF/FF, x=80 yields FF/FF/00, x=639 yields 00/00/00, all zero during blanking.
